// File: rtl/filtrado_param.sv
// Three-band second-order DF-I IIR filter bank with run-time loadable coefficients.
// Define FILTRADO_SAT_EN to saturate band and sum limits; otherwise they wrap.
module filtrado_param #(
  parameter int WIDTH = 25,
  parameter int FRAC  = 16,
  parameter int GUARD = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic [WIDTH-1:0] u,
  input  logic             sw_B,
  input  logic             sw_M,
  input  logic             sw_A,
  input  logic             coef_we,
  input  logic [3:0]       coef_addr,
  input  logic [WIDTH-1:0] coef_data,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] out_B,
  output logic [WIDTH-1:0] out_M,
  output logic [WIDTH-1:0] out_A,
  output logic             y_valid,
  output logic             busy,
  output logic             overrun,
  output logic             coef_err
);

  localparam int NB   = 3;
  localparam int NC   = 5 * NB;
  localparam int ACCW = 2 * WIDTH + GUARD;
  localparam int SUMW = WIDTH + 2;
  localparam logic [WIDTH-1:0]       COEF_ONE = WIDTH'(1) << FRAC;
  localparam logic signed [ACCW-1:0] RND_HALF = ACCW'(1) << (FRAC - 1);
`ifdef FILTRADO_SAT_EN
  localparam logic signed [WIDTH-1:0] WMAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] WMIN   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [ACCW-1:0]  ACC_HI = ACCW'(WMAX);
  localparam logic signed [ACCW-1:0]  ACC_LO = ACCW'(WMIN);
  localparam logic signed [SUMW-1:0]  SUM_HI = SUMW'(WMAX);
  localparam logic signed [SUMW-1:0]  SUM_LO = SUMW'(WMIN);
`endif

  typedef enum logic [1:0] {IDLE, MAC, SUM} state_t;

  state_t state_q, state_d;
  logic [2:0] k_q, k_d;

  logic signed [WIDTH-1:0] x0_q, x1_q, x2_q;
  logic [WIDTH-1:0] y_q;
  logic y_valid_q, overrun_q, coef_err_q;
  logic accept, coef_wr;
  logic [NB-1:0] sw_en;

  logic signed [WIDTH-1:0] coef_w   [NC];
  logic signed [WIDTH-1:0] band_out [NB];
  logic signed [SUMW-1:0]  masked   [NB];
  logic signed [SUMW-1:0]  ysum;
  logic [WIDTH-1:0] ysum_lim;

  assign busy    = (state_q != IDLE);
  assign accept  = (state_q == IDLE) && rx;
  assign coef_wr = coef_we && (state_q == IDLE) && (coef_addr != 4'hF);
  assign sw_en   = {sw_A, sw_M, sw_B};

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (rx) begin
          state_d = MAC;
          k_d     = 3'd0;
        end
      end
      MAC: begin
        k_d = k_q + 3'd1;
        if (k_q == 3'd4) state_d = SUM;
      end
      SUM:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x0_q       <= '0;
      x1_q       <= '0;
      x2_q       <= '0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
      overrun_q  <= 1'b0;
      coef_err_q <= 1'b0;
    end else begin
      if (accept) x0_q <= u;
      if (state_q == SUM) begin
        x1_q <= x0_q;
        x2_q <= x1_q;
        y_q  <= ysum_lim;
      end
      y_valid_q  <= (state_q == SUM);
      overrun_q  <= rx && busy;
      coef_err_q <= coef_we && (busy || coef_addr == 4'hF);
    end
  end

  // Coefficient file: address band*5+k, reset to pass-through (b0 = 1.0).
  genvar gi;
  generate
    for (gi = 0; gi < NC; gi++) begin : g_coef
      logic signed [WIDTH-1:0] c_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          c_q <= (gi % 5 == 0) ? COEF_ONE : '0;
        end else if (coef_wr && coef_addr == 4'(gi)) begin
          c_q <= coef_data;
        end
      end
      assign coef_w[gi] = c_q;
    end

    for (gi = 0; gi < NB; gi++) begin : g_band
      logic signed [WIDTH-1:0]   y1_q, y2_q, out_q, op_c, op_d, lim;
      logic signed [2*WIDTH-1:0] prod;
      logic signed [ACCW-1:0]    acc_q, acc_d, term, rnd;

      always_comb begin
        op_c = coef_w[gi*5];
        op_d = x0_q;
        case (k_q)
          3'd1: begin op_c = coef_w[gi*5+1]; op_d = x1_q; end
          3'd2: begin op_c = coef_w[gi*5+2]; op_d = x2_q; end
          3'd3: begin op_c = coef_w[gi*5+3]; op_d = y1_q; end
          3'd4: begin op_c = coef_w[gi*5+4]; op_d = y2_q; end
          default: ;
        endcase
      end

      assign prod = op_c * op_d;
      assign term = {{GUARD{prod[2*WIDTH-1]}}, prod};

      // k=0 restarts the accumulator; feedback terms (k=3,4) are subtracted.
      always_comb begin
        acc_d = (k_q == 3'd0) ? '0 : acc_q;
        if (k_q >= 3'd3) acc_d = acc_d - term;
        else             acc_d = acc_d + term;
      end

      assign rnd = acc_q + RND_HALF;
`ifdef FILTRADO_SAT_EN
      logic signed [ACCW-1:0] shr;
      assign shr = rnd >>> FRAC;
      always_comb begin
        if (shr > ACC_HI)      lim = WMAX;
        else if (shr < ACC_LO) lim = WMIN;
        else                   lim = shr[WIDTH-1:0];
      end
`else
      assign lim = WIDTH'(rnd >>> FRAC);
`endif

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          acc_q <= '0;
          y1_q  <= '0;
          y2_q  <= '0;
          out_q <= '0;
        end else begin
          if (state_q == MAC) acc_q <= acc_d;
          if (state_q == SUM) begin
            y2_q  <= y1_q;
            y1_q  <= lim;
            out_q <= lim;
          end
        end
      end

      assign band_out[gi] = out_q;
      assign masked[gi]   = sw_en[gi] ? SUMW'(lim) : '0;
    end
  endgenerate

  assign ysum = masked[0] + masked[1] + masked[2];

`ifdef FILTRADO_SAT_EN
  always_comb begin
    if (ysum > SUM_HI)      ysum_lim = WMAX;
    else if (ysum < SUM_LO) ysum_lim = WMIN;
    else                    ysum_lim = ysum[WIDTH-1:0];
  end
`else
  assign ysum_lim = WIDTH'(ysum);
`endif

  assign y        = y_q;
  assign out_B    = band_out[0];
  assign out_M    = band_out[1];
  assign out_A    = band_out[2];
  assign y_valid  = y_valid_q;
  assign overrun  = overrun_q;
  assign coef_err = coef_err_q;

endmodule
